// File: rtl/bk_chunk_sequencer_pkg.sv
// bk_chunk_sequencer_pkg: shared FSM encoding and adder slice width
package bk_chunk_sequencer_pkg;
  localparam int SLICE_W = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/bk_chunk_sequencer_if.sv
// bk_chunk_sequencer_if: operand/result handshake bundle for the chunk sequencer
interface bk_chunk_sequencer_if
  import bk_chunk_sequencer_pkg::*;
#(
  parameter int CHUNKS = 4
);
  localparam int N = SLICE_W * CHUNKS;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         busy;
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, clear, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/brent_kung_cin.sv
// brent_kung_cin: 6-bit Brent-Kung prefix adder with carry-in; sum[6] is carry-out, sum[7] is 0
module brent_kung_cin (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cin,
  output logic [7:0] sum
);
  logic [5:0] g, p;
  logic g0c, g10, g32, p32, g54, p54, g30, g20, g40, g50;
  assign g = a & b;
  assign p = a ^ b;
  // carry-in folded into bit 0 generate so every prefix is a true carry
  assign g0c = g[0] | (p[0] & cin);
  assign g10 = g[1] | (p[1] & g0c);
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g54 = g[5] | (p[5] & g[4]);
  assign p54 = p[5] & p[4];
  assign g30 = g32 | (p32 & g10);
  assign g50 = g54 | (p54 & g30);
  assign g20 = g[2] | (p[2] & g10);
  assign g40 = g[4] | (p[4] & g30);
  assign sum = {1'b0, g50, p ^ {g40, g30, g20, g10, g0c, cin}};
endmodule

// File: rtl/bk_chunk_sequencer.sv
// bk_chunk_sequencer: N-bit add/sub computed LSB-first through one shared 6-bit Brent-Kung slice
module bk_chunk_sequencer
  import bk_chunk_sequencer_pkg::*;
#(
  parameter int CHUNKS = 4
) (
  input logic clk,
  input logic rst_n,
  bk_chunk_sequencer_if.slave bus
);
  localparam int W = SLICE_W;
  localparam int N = W * CHUNKS;
  localparam int IW = $clog2(CHUNKS);
  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [N-1:0]  a_r, b_r, sum_r;
  logic          cout_r;
  logic [W-1:0]  a_s, b_s;
  logic [7:0]    res;
  logic          unused_msb;
  assign a_s = a_r[idx*W +: W];
  assign b_s = b_r[idx*W +: W];
  assign unused_msb = res[7];
  brent_kung_cin u_add (.a(a_s), .b(b_s), .cin(carry), .sum(res));
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.out_sum   = sum_r;
  assign bus.out_cout  = cout_r;
  // accept operands, ripple one slice per cycle, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (bus.clear) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state <= RUN;
          a_r   <= bus.in_a;
          b_r   <= bus.in_sub ? ~bus.in_b : bus.in_b;
          carry <= bus.in_sub ? 1'b1 : bus.in_cin;
          idx   <= '0;
        end
        RUN: begin
          sum_r[idx*W +: W] <= res[W-1:0];
          carry <= res[W];
          idx   <= idx + 1'b1;
          if (idx == IW'(CHUNKS - 1)) begin
            state  <= DONE;
            cout_r <= res[W];
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bk_chunk_sequencer.sv
// tb_bk_chunk_sequencer: directed and random checks of the chunked add/sub sequencer
module tb_bk_chunk_sequencer;
  localparam int CHUNKS = 4;
  localparam int N = 6 * CHUNKS;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  int m_left = 0;
  bit m_done = 1'b0;
  logic [N-1:0] m_sum = '0;
  logic m_cout = 1'b0;
  always #5 clk = ~clk;
  bk_chunk_sequencer_if #(.CHUNKS(CHUNKS)) bus ();
  bk_chunk_sequencer #(.CHUNKS(CHUNKS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: result is plain N-bit arithmetic, ready CHUNKS edges after accept
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_sum", bus.out_sum, 0);
      chk("rst_cout", bus.out_cout, 0);
      m_left = 0;
      m_done = 1'b0;
    end else begin
      chk("m_ready", bus.in_ready, (m_left == 0) && !m_done);
      chk("m_valid", bus.out_valid, m_done);
      chk("m_busy", bus.busy, (m_left != 0) || m_done);
      if (m_done) begin
        chk("m_sum", bus.out_sum, m_sum);
        chk("m_cout", bus.out_cout, m_cout);
      end
      if (bus.clear) begin
        m_left = 0;
        m_done = 1'b0;
      end else if (m_left == 0 && !m_done) begin
        if (bus.in_valid) begin
          {m_cout, m_sum} = bus.in_sub ? {1'b0, bus.in_a} + {1'b0, ~bus.in_b} + (N+1)'(1)
                                       : {1'b0, bus.in_a} + {1'b0, bus.in_b} + (N+1)'(bus.in_cin);
          m_left = CHUNKS;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (bus.out_ready) begin
        m_done = 1'b0;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic cin, input logic sub, input logic [N-1:0] es, input logic ec);
    int cnt = 0;
    while (!bus.in_ready && cnt < 50) begin step(); cnt++; end
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_cin = cin;
    bus.in_sub = sub;
    step();
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 50) begin step(); cnt++; end
    chk({nm, "_lat"}, (N+1)'(cnt + 1), (N+1)'(CHUNKS + 1));
    chk({nm, "_sum"}, bus.out_sum, es);
    chk({nm, "_cout"}, bus.out_cout, ec);
  endtask
  task automatic take();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask
  initial begin
    int acc = 0;
    int cyc = 0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_cin = 1'b0;
    bus.in_sub = 1'b0;
    bus.clear = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", bus.in_ready, 1);
    op("add_wrap", 24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1);
    take();
    op("add_cin", 24'h0000FF, 24'h000100, 1'b1, 1'b0, 24'h000200, 1'b0);
    take();
    op("sub_pos", 24'h000010, 24'h000001, 1'b0, 1'b1, 24'h00000F, 1'b1);
    take();
    op("sub_cin_ign", 24'h000005, 24'h000005, 1'b1, 1'b1, 24'h000000, 1'b1);
    take();
    op("sub_neg", 24'h000001, 24'h000002, 1'b0, 1'b1, 24'hFFFFFF, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_a = 24'h0A0A0A;
    bus.in_b = 24'h050505;
    repeat (3) begin
      step();
      chk("bp_sum", bus.out_sum, 24'hFFFFFF);
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    take();
    chk("bp_idle", bus.in_ready, 1);
    chk("bp_drop", bus.out_valid, 0);
    bus.in_valid = 1'b1;
    bus.in_a = 24'hABCDEF;
    bus.in_b = 24'h135791;
    bus.in_sub = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clr_idle", bus.in_ready, 1);
    chk("clr_busy", bus.busy, 0);
    repeat (8) begin
      step();
      chk("clr_novalid", bus.out_valid, 0);
    end
    op("post_clr", 24'h123456, 24'h111111, 1'b0, 1'b0, 24'h234567, 1'b0);
    take();
    bus.in_valid = 1'b1;
    bus.in_a = 24'h3F3F3F;
    bus.in_b = 24'h000000;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rrun_valid", bus.out_valid, 0);
    chk("rrun_busy", bus.busy, 0);
    chk("rrun_sum", bus.out_sum, 0);
    chk("rrun_cout", bus.out_cout, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rrun_ready", bus.in_ready, 1);
    repeat (10) begin
      step();
      chk("rrun_novalid", bus.out_valid, 0);
    end
    while (acc < 50 && cyc < 20000) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a = N'($urandom);
      bus.in_b = N'($urandom);
      bus.in_cin = 1'($urandom_range(0, 1));
      bus.in_sub = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.in_valid && bus.in_ready) acc++;
      step();
      cyc++;
    end
    chk("rand_ops", (N+1)'(acc), (N+1)'(50));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bk_chunk_sequencer.md
BK_CHUNK_SEQUENCER -- requirements
Module: bk_chunk_sequencer

Interface
REQ-001 SHALL have parameter CHUNKS, default 4: number of 6-bit slices per operation (legal 2..8).
REQ-002 SHALL have localparam W = 6 (adder slice width) and localparam N = 6*CHUNKS (operand width).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block accepts operand set this cycle.
REQ-007 in_a  input  N  operand A.
REQ-008 in_b  input  N  operand B.
REQ-009 in_cin  input  1  carry-in (ignored when in_sub=1).
REQ-010 in_sub  input  1  1 = compute A - B.
REQ-011 clear  input  1  synchronous abort.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 out_sum  output  N  result.
REQ-015 out_cout  output  1  final carry; for subtract, 1 = no borrow.
REQ-016 busy  output  1  high in RUN or DONE.

Function
REQ-017 SHALL time-share one 6-bit Brent-Kung adder slice over CHUNKS cycles, LSB slice first.
REQ-018 The adder result SHALL be used as bits [5:0] = slice sum and bit [6] = slice carry; bit [7] is ignored.
REQ-019 FSM states SHALL be IDLE, RUN and DONE; in_ready = (state==IDLE).
REQ-020 IDLE->RUN on in_valid & in_ready. On that edge: latch A; latch B (inverted when in_sub); set carry register to in_sub ? 1 : in_cin; set slice index to 0.
REQ-021 In RUN, each cycle SHALL add slice[idx] of A and B with the carry register, write the 6-bit sum into out_sum slice[idx], store the slice carry, and increment idx.
REQ-022 RUN->DONE on the edge that processes idx == CHUNKS-1; out_cout SHALL take that slice carry.
REQ-023 Latency SHALL be exactly CHUNKS+1 cycles: accept edge to first edge with out_valid=1 (5 for CHUNKS=4).
REQ-024 out_valid = (state==DONE). out_sum and out_cout SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 DONE->IDLE on out_ready. Throughput is one operation per CHUNKS+2 cycles with no input overlap.
REQ-026 Arithmetic is modulo 2^N; no overflow flag; out_cout is the only carry-out indication.
REQ-027 clear=1 in any state SHALL force IDLE on the next edge, drop out_valid and discard any partial result; clear has priority over in_valid and out_ready.
REQ-028 in_valid while not in IDLE SHALL be ignored (no accept); input data is sampled only at the accept edge.
REQ-029 Partial out_sum bits SHALL NOT be guaranteed while in RUN; only DONE contents are defined.

Reset
REQ-030 rst_n low SHALL immediately force: state=IDLE, idx=0, carry=0, out_sum=0, out_cout=0, out_valid=0, busy=0, in_ready=1 once released.
REQ-031 Reset during RUN or DONE SHALL abandon the operation; no result is emitted after release.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the slice width constant 6.
REQ-033 SHALL instantiate exactly one existing brent_kung_cin as its sole sub-module; no other adder logic is permitted.
REQ-034 The slice index SHALL be ceil(log2(CHUNKS)) bits wide; slice selection is a mux on idx.

Verification (CHUNKS=4)
REQ-035 A=0xFFFFFF, B=0x000001, cin=0, sub=0 -> out_sum=0x000000, out_cout=1, out_valid on the 5th edge after accept.
REQ-036 A=0x000010, B=0x000001, sub=1 -> out_sum=0x00000F, out_cout=1. Repeat with A=0x000001, B=0x000002 -> out_sum=0xFFFFFF, out_cout=0.
REQ-037 Backpressure: hold out_ready=0 for 3 cycles after out_valid -> out_sum stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-038 clear=1 on the 2nd RUN cycle -> IDLE next edge, out_valid never asserted; next op A=0x123456, B=0x111111 -> out_sum=0x234567, out_cout=0.
REQ-039 rst_n low mid-RUN -> all outputs 0 immediately, in_ready=1 after release, no spurious out_valid.
REQ-040 Back-to-back: 50 random ops with random in_valid/out_ready -> every result matches an N-bit add/sub reference model, in order.
